// File: rtl/flash_audio_pkg.sv
// Shared constants for the flash-to-codec playback sequencer.
// Holds word geometry and the playback and fetch state encodings.
package flash_audio_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned SHIFT_LEN = 16;

    // Playback state encoding
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StPrime  = 3'd1;
    localparam logic [2:0] StWaitLr = 3'd2;
    localparam logic [2:0] StShift  = 3'd3;
    localparam logic [2:0] StPaused = 3'd4;

    // Fetch engine encoding
    localparam logic [1:0] FsIdle = 2'd0;
    localparam logic [1:0] FsRead = 2'd1;
    localparam logic [1:0] FsHold = 2'd2;

endpackage

// File: rtl/audio_word_shifter.sv
// Loads one audio word and shifts it out MSB-first, one bit per clock.
// Output is forced to 0 whenever no word is being shifted.
module audio_word_shifter
    import flash_audio_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_dat,
    output logic              o_done
);

    localparam logic [3:0] LastBit = 4'(SHIFT_LEN - 1);

    logic [WORD_W-1:0] sh_q;
    logic [3:0]        cnt_q;
    logic              active_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (i_load) begin
            sh_q     <= i_data;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            sh_q  <= {sh_q[WORD_W-2:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == LastBit) begin
                active_q <= 1'b0;
            end
        end
    end

    assign o_dat  = active_q & sh_q[WORD_W-1];
    assign o_done = active_q && (cnt_q == LastBit);

endmodule

// File: rtl/flash_audio_seq.sv
// Playback sequencer: fetches words from parallel flash into a single buffer
// and serialises each one onto the codec DAC line on every LRCK edge.
module flash_audio_seq
    import flash_audio_pkg::*;
#(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned FLASH_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_play,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic              i_daclrck,
    input  logic [15:0]       i_flash_dq,
    output logic [ADDR_W-1:0] o_flash_addr,
    output logic              o_flash_oe_n,
    output logic              o_aud_dacdat,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [3:0] WaitLast = 4'(FLASH_WAIT - 1);

    logic [2:0]        state_q, state_d;
    logic              pause_q, pause_d;
    logic              done_q, done_d;
    logic              lrck_q;
    logic [ADDR_W-1:0] start_q, end_q, cur_q;
    logic              loop_q, remain_q;
    logic [1:0]        fst_q;
    logic [3:0]        wcnt_q;
    logic              oe_n_q;
    logic [WORD_W-1:0] buf_q;
    logic              buf_valid_q, buf_last_q, shift_last_q;

    logic lr_edge, play_ok, pause_now, fetch_busy, fetch_start, fetch_ready;
    logic shift_load, shift_done;

    assign lr_edge     = i_daclrck != lrck_q;
    assign play_ok     = (state_q == StIdle) && i_play && !i_stop && !i_pause &&
                         (i_end_addr >= i_start_addr);
    assign pause_now   = pause_q | i_pause;
    assign fetch_busy  = fst_q != FsIdle;
    assign fetch_ready = buf_valid_q && !fetch_busy;
    // The first fetch launches on the accepting edge so OE falls the next cycle
    assign fetch_start = play_ok ||
                         (!fetch_busy && !buf_valid_q && remain_q && !i_stop &&
                          (state_q == StPrime || state_q == StWaitLr || state_q == StShift));

    always_comb begin
        state_d    = state_q;
        pause_d    = pause_q;
        done_d     = 1'b0;
        shift_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (play_ok) begin
                    state_d = StPrime;
                    pause_d = 1'b0;
                end
            end
            StPrime, StWaitLr: begin
                if (i_pause) pause_d = 1'b1;
                if (fetch_ready && pause_now) begin
                    state_d = StPaused;
                    pause_d = 1'b0;
                end else if (state_q == StPrime) begin
                    if (fetch_ready) state_d = StWaitLr;
                end else if (lr_edge && buf_valid_q) begin
                    shift_load = 1'b1;
                    state_d    = StShift;
                end
            end
            StShift: begin
                if (i_pause) pause_d = 1'b1;
                if (shift_done) begin
                    if (shift_last_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        pause_d = 1'b0;
                    end else if (pause_now) begin
                        state_d = StPaused;
                        pause_d = 1'b0;
                    end else begin
                        state_d = StWaitLr;
                    end
                end
            end
            StPaused: begin
                if (i_play && !i_pause) state_d = StWaitLr;
            end
            default: state_d = StIdle;
        endcase
        if (i_stop) begin
            state_d    = StIdle;
            pause_d    = 1'b0;
            done_d     = 1'b0;
            shift_load = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            pause_q      <= 1'b0;
            done_q       <= 1'b0;
            lrck_q       <= 1'b0;
            start_q      <= '0;
            end_q        <= '0;
            cur_q        <= '0;
            loop_q       <= 1'b0;
            remain_q     <= 1'b0;
            fst_q        <= FsIdle;
            wcnt_q       <= '0;
            oe_n_q       <= 1'b1;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            buf_last_q   <= 1'b0;
            shift_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
            done_q  <= done_d;
            lrck_q  <= i_daclrck;
            if (play_ok) begin
                start_q  <= i_start_addr;
                end_q    <= i_end_addr;
                cur_q    <= i_start_addr;
                loop_q   <= i_loop;
                remain_q <= 1'b1;
            end
            if (shift_load) begin
                buf_valid_q  <= 1'b0;
                shift_last_q <= buf_last_q;
            end
            if (i_stop) begin
                fst_q       <= FsIdle;
                oe_n_q      <= 1'b1;
                buf_valid_q <= 1'b0;
                remain_q    <= 1'b0;
            end else begin
                unique case (fst_q)
                    FsIdle: begin
                        if (fetch_start) begin
                            fst_q  <= FsRead;
                            oe_n_q <= 1'b0;
                            wcnt_q <= '0;
                        end
                    end
                    FsRead: begin
                        wcnt_q <= wcnt_q + 4'd1;
                        if (wcnt_q == WaitLast) begin
                            buf_q       <= i_flash_dq;
                            buf_valid_q <= 1'b1;
                            buf_last_q  <= (cur_q == end_q) && !loop_q;
                            oe_n_q      <= 1'b1;
                            fst_q       <= FsHold;
                        end
                    end
                    // Address advances one cycle after OE rises to keep it stable
                    FsHold: begin
                        fst_q <= FsIdle;
                        if (cur_q == end_q) begin
                            if (loop_q) cur_q <= start_q;
                            else        remain_q <= 1'b0;
                        end else begin
                            cur_q <= cur_q + ADDR_W'(1);
                        end
                    end
                    default: fst_q <= FsIdle;
                endcase
            end
        end
    end

    audio_word_shifter u_shifter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (shift_load),
        .i_clear (i_stop),
        .i_data  (buf_q),
        .o_dat   (o_aud_dacdat),
        .o_done  (shift_done)
    );

    assign o_flash_addr = play_ok ? i_start_addr : cur_q;
    assign o_flash_oe_n = oe_n_q;
    assign o_busy       = state_q != StIdle;
    assign o_done       = done_q;

endmodule

// File: tb/tb_flash_audio_seq.sv
// Directed bench for flash_audio_seq: a negedge monitor records flash reads,
// serialised words and done pulses; each test task checks them against hand values.
module tb_flash_audio_seq;

    localparam int unsigned ADDR_W     = 22;
    localparam int unsigned FLASH_WAIT = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_play = 1'b0, i_pause = 1'b0, i_stop = 1'b0, i_loop = 1'b0;
    logic [ADDR_W-1:0] i_start_addr = '0, i_end_addr = '0;
    logic              i_daclrck = 1'b0;
    logic [15:0]       i_flash_dq;
    logic [ADDR_W-1:0] o_flash_addr;
    logic              o_flash_oe_n, o_aud_dacdat, o_busy, o_done;

    flash_audio_seq #(
        .ADDR_W     (ADDR_W),
        .FLASH_WAIT (FLASH_WAIT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_play       (i_play),
        .i_pause      (i_pause),
        .i_stop       (i_stop),
        .i_loop       (i_loop),
        .i_start_addr (i_start_addr),
        .i_end_addr   (i_end_addr),
        .i_daclrck    (i_daclrck),
        .i_flash_dq   (i_flash_dq),
        .o_flash_addr (o_flash_addr),
        .o_flash_oe_n (o_flash_oe_n),
        .o_aud_dacdat (o_aud_dacdat),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] flash_word(input logic [ADDR_W-1:0] a);
        case (a)
            22'h10:  return 16'hA5F0;
            22'h11:  return 16'h1234;
            22'h12:  return 16'hFFFF;
            22'h00:  return 16'hC3C3;
            22'h01:  return 16'h5A5A;
            default: return 16'hDEAD;
        endcase
    endfunction
    assign i_flash_dq = flash_word(o_flash_addr);

    int n_cmp = 0, n_fail = 0;

    // Monitor state
    int cyc = 0, play_cyc = -1, reads = 0, done_cnt = 0, done_cyc = -1;
    int addr_viol = 0, tail_viol = 0, run_len = 0, cap_pos = 0;
    int lr_half = 32, lr_cnt = 0;
    logic lr_en = 1'b0, prev_oe = 1'b1;
    logic [ADDR_W-1:0] prev_addr, low_addr;
    logic [15:0] cap_word = '0;
    logic [ADDR_W-1:0] rd_addr_q[$];
    logic [15:0] word_q[$];
    int run_q[$], edge_q[$], fall_q[$];

    always @(negedge i_clk) begin
        cyc++;
        if (i_play) play_cyc = cyc;
        if (prev_oe === 1'b1 && o_flash_oe_n === 1'b0) begin
            reads++;
            rd_addr_q.push_back(o_flash_addr);
            fall_q.push_back(cyc);
            if (o_flash_addr !== prev_addr) addr_viol++;
            low_addr = o_flash_addr;
            run_len  = 1;
        end else if (prev_oe === 1'b0 && o_flash_oe_n === 1'b0) begin
            run_len++;
            if (o_flash_addr !== low_addr) addr_viol++;
        end else if (prev_oe === 1'b0 && o_flash_oe_n === 1'b1) begin
            run_q.push_back(run_len);
            if (o_flash_addr !== low_addr) addr_viol++;
        end
        prev_oe   = o_flash_oe_n;
        prev_addr = o_flash_addr;
        if (o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cap_pos >= 1 && cap_pos <= 16) begin
            cap_word = {cap_word[14:0], o_aud_dacdat};
            cap_pos++;
        end else if (cap_pos == 17) begin
            if (o_aud_dacdat !== 1'b0) tail_viol++;
            word_q.push_back(cap_word);
            cap_pos = 0;
        end
        if (lr_en) begin
            lr_cnt++;
            if (lr_cnt >= lr_half) begin
                lr_cnt    = 0;
                i_daclrck = ~i_daclrck;
                edge_q.push_back(cyc);
                cap_pos  = 1;
                cap_word = '0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic mon_clear();
        reads = 0; done_cnt = 0; done_cyc = -1; addr_viol = 0; tail_viol = 0; cap_pos = 0;
        rd_addr_q.delete(); word_q.delete(); run_q.delete(); edge_q.delete(); fall_q.delete();
    endtask

    task automatic start_play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                              input logic lp);
        i_start_addr = s;
        i_end_addr   = e;
        i_loop       = lp;
        i_play       = 1'b1;
        step(1);
        i_play       = 1'b0;
    endtask

    task automatic lr_start(input int half);
        lr_half = half;
        lr_cnt  = half - 1;
        lr_en   = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        step(2);
        n_cmp++; if (o_flash_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b want 1", o_flash_oe_n); end
        n_cmp++; if (o_aud_dacdat !== 1'b0) begin n_fail++; $display("FAIL reset_dacdat: got %b want 0", o_aud_dacdat); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
        n_cmp++; if (o_flash_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", o_flash_addr); end
        i_rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_playback();
        logic [15:0] exp_w[3] = '{16'hA5F0, 16'h1234, 16'hFFFF};
        logic [15:0] got;
        int k, exp_i;
        mon_clear();
        start_play(22'h10, 22'h12, 1'b0);
        step(12);
        lr_start(32);
        k = 0;
        while (o_busy && k < 400) begin step(1); k++; end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL play_timeout: busy=%b want 0", o_busy); end
        step(3);
        lr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = (i < word_q.size()) ? word_q[i] : 16'hxxxx;
            n_cmp++; if (got !== exp_w[i]) begin n_fail++; $display("FAIL play_word%0d: got %h want %h", i, got, exp_w[i]); end
            got = (i < run_q.size()) ? 16'(run_q[i]) : 16'hxxxx;
            n_cmp++; if (got !== 16'(FLASH_WAIT)) begin n_fail++; $display("FAIL oe_width%0d: got %0d want %0d", i, got, FLASH_WAIT); end
            got = (i < rd_addr_q.size()) ? 16'(rd_addr_q[i]) : 16'hxxxx;
            n_cmp++; if (got !== 16'(22'h10 + i)) begin n_fail++; $display("FAIL rd_addr%0d: got %h want %h", i, got, 16'h10 + i); end
        end
        n_cmp++; if (reads !== 3) begin n_fail++; $display("FAIL play_reads: got %0d want 3", reads); end
        n_cmp++; if (addr_viol !== 0) begin n_fail++; $display("FAIL addr_stable: got %0d violations want 0", addr_viol); end
        n_cmp++; if (tail_viol !== 0) begin n_fail++; $display("FAIL play_tail: got %0d violations want 0", tail_viol); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL play_done_cnt: got %0d want 1", done_cnt); end
        exp_i = (edge_q.size() >= 3) ? edge_q[2] + 17 : -100;
        n_cmp++; if (done_cyc !== exp_i) begin n_fail++; $display("FAIL play_done_cyc: got %0d want %0d", done_cyc, exp_i); end
        exp_i = play_cyc + 1;
        k = (fall_q.size() >= 1) ? fall_q[0] : -1;
        n_cmp++; if (k !== exp_i) begin n_fail++; $display("FAIL first_read_cyc: got %0d want %0d", k, exp_i); end
        exp_i = (edge_q.size() >= 1) ? edge_q[0] + 2 : -100;
        k = (fall_q.size() >= 2) ? fall_q[1] : -1;
        n_cmp++; if (k !== exp_i) begin n_fail++; $display("FAIL prefetch_cyc: got %0d want %0d", k, exp_i); end
    endtask

    task automatic test_loop();
        logic [15:0] got, exp;
        int k;
        mon_clear();
        start_play(22'h0, 22'h1, 1'b1);
        step(12);
        lr_start(20);
        k = 0;
        while (word_q.size() < 8 && k < 600) begin step(1); k++; end
        n_cmp++; if (word_q.size() < 8) begin n_fail++; $display("FAIL loop_timeout: got %0d words want 8", word_q.size()); end
        for (int i = 0; i < 8; i++) begin
            exp = (i % 2 == 0) ? 16'hC3C3 : 16'h5A5A;
            got = (i < word_q.size()) ? word_q[i] : 16'hxxxx;
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL loop_word%0d: got %h want %h", i, got, exp); end
            got = (i < rd_addr_q.size()) ? 16'(rd_addr_q[i]) : 16'hxxxx;
            n_cmp++; if (got !== 16'(i % 2)) begin n_fail++; $display("FAIL loop_addr%0d: got %h want %h", i, got, i % 2); end
        end
        n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL loop_done: got %0d want 0", done_cnt); end
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy: got %b want 1", o_busy); end
        i_stop = 1'b1;
        step(1);
        i_stop = 1'b0;
        lr_en  = 1'b0;
        step(2);
    endtask

    task automatic test_pause();
        logic [15:0] lastw, got;
        int k, nz, exp_i;
        mon_clear();
        start_play(22'h10, 22'h12, 1'b0);
        step(12);
        lr_start(32);
        k = 0;
        while (!(word_q.size() == 1 && cap_pos == 8) && k < 300) begin step(1); k++; end
        n_cmp++; if (cap_pos != 8) begin n_fail++; $display("FAIL pause_sync: got cap_pos %0d want 8", cap_pos); end
        i_pause = 1'b1;
        step(1);
        i_pause = 1'b0;
        step(100);
        n_cmp++; if (reads !== 3) begin n_fail++; $display("FAIL pause_reads: got %0d want 3", reads); end
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL pause_busy: got %b want 1", o_busy); end
        nz = 0;
        for (int i = 2; i < word_q.size(); i++) if (word_q[i] != 16'h0) nz++;
        n_cmp++; if (nz !== 0) begin n_fail++; $display("FAIL pause_silent: got %0d nonzero words want 0", nz); end
        i_play = 1'b1;
        step(1);
        i_play = 1'b0;
        k = 0;
        while (o_busy && k < 300) begin step(1); k++; end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL resume_timeout: busy=%b want 0", o_busy); end
        step(3);
        lr_en = 1'b0;
        got = (word_q.size() >= 1) ? word_q[0] : 16'hxxxx;
        n_cmp++; if (got !== 16'hA5F0) begin n_fail++; $display("FAIL pause_word0: got %h want a5f0", got); end
        got = (word_q.size() >= 2) ? word_q[1] : 16'hxxxx;
        n_cmp++; if (got !== 16'h1234) begin n_fail++; $display("FAIL pause_word1: got %h want 1234", got); end
        lastw = (word_q.size() >= 1) ? word_q[word_q.size()-1] : 16'hxxxx;
        n_cmp++; if (lastw !== 16'hFFFF) begin n_fail++; $display("FAIL resume_word2: got %h want ffff", lastw); end
        nz = 0;
        foreach (word_q[i]) if (word_q[i] != 16'h0) nz++;
        n_cmp++; if (nz !== 3) begin n_fail++; $display("FAIL pause_nz_words: got %0d want 3", nz); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL pause_done_cnt: got %0d want 1", done_cnt); end
        exp_i = (edge_q.size() >= 1) ? edge_q[edge_q.size()-1] + 17 : -100;
        n_cmp++; if (done_cyc !== exp_i) begin n_fail++; $display("FAIL pause_done_cyc: got %0d want %0d", done_cyc, exp_i); end
        n_cmp++; if (tail_viol !== 0) begin n_fail++; $display("FAIL pause_tail: got %0d want 0", tail_viol); end
    endtask

    task automatic test_stop();
        int r0;
        mon_clear();
        lr_start(32);
        start_play(22'h10, 22'h12, 1'b0);
        step(1);
        i_stop = 1'b1;
        step(1);
        i_stop = 1'b0;
        n_cmp++; if (o_flash_oe_n !== 1'b1) begin n_fail++; $display("FAIL stop_oe_n: got %b want 1", o_flash_oe_n); end
        n_cmp++; if (o_aud_dacdat !== 1'b0) begin n_fail++; $display("FAIL stop_dacdat: got %b want 0", o_aud_dacdat); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b want 0", o_busy); end
        step(60);
        lr_en = 1'b0;
        r0 = (run_q.size() >= 1) ? run_q[0] : -1;
        n_cmp++; if (r0 !== 2) begin n_fail++; $display("FAIL stop_oe_width: got %0d want 2", r0); end
        n_cmp++; if (reads !== 1) begin n_fail++; $display("FAIL stop_reads: got %0d want 1", reads); end
        n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL stop_done: got %0d want 0", done_cnt); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy_late: got %b want 0", o_busy); end
    endtask

    task automatic test_reset_mid_shift();
        int k;
        mon_clear();
        start_play(22'h10, 22'h12, 1'b0);
        step(12);
        lr_start(32);
        k = 0;
        while (!(word_q.size() == 0 && cap_pos == 4) && k < 200) begin step(1); k++; end
        n_cmp++; if (o_flash_oe_n !== 1'b0) begin n_fail++; $display("FAIL rst_pre_read: got oe_n %b want 0", o_flash_oe_n); end
        i_rst_n = 1'b0;
        step(1);
        n_cmp++; if (o_flash_oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n: got %b want 1", o_flash_oe_n); end
        n_cmp++; if (o_aud_dacdat !== 1'b0) begin n_fail++; $display("FAIL rst_dacdat: got %b want 0", o_aud_dacdat); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        i_rst_n = 1'b1;
        step(40);
        lr_en = 1'b0;
        n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rst_done: got %0d want 0", done_cnt); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_late: got %b want 0", o_busy); end
    endtask

    task automatic test_bad_range();
        mon_clear();
        start_play(22'h20, 22'h1F, 1'b0);
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bad_range_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_flash_oe_n !== 1'b1) begin n_fail++; $display("FAIL bad_range_oe: got %b want 1", o_flash_oe_n); end
        step(10);
        n_cmp++; if (reads !== 0) begin n_fail++; $display("FAIL bad_range_reads: got %0d want 0", reads); end
        i_start_addr = 22'h10;
        i_end_addr   = 22'h12;
        i_play       = 1'b1;
        i_stop       = 1'b1;
        step(1);
        i_play       = 1'b0;
        i_stop       = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL play_stop_busy: got %b want 0", o_busy); end
        step(10);
        n_cmp++; if (reads !== 0) begin n_fail++; $display("FAIL play_stop_reads: got %0d want 0", reads); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL play_stop_busy_late: got %b want 0", o_busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        step(1);
        test_reset();
        test_playback();
        test_loop();
        test_pause();
        test_stop();
        test_reset_mid_shift();
        test_bad_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
